// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_op_sequencer                                              |
// | Purpose  : Issues one register-file instruction at a time to an external |
// |            ALU. It reads operands, captures the result and flags, then   |
// |            holds the result until it is handshaked and written back.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_op_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // instruction channel: {opcode[9:6], rd[5:4], rs1[3:2], rs2[1:0]}
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [9:0]           instr,
  // external register load / readback
  input  logic                 wr_en,
  input  logic [1:0]           wr_addr,
  input  logic [BUS_WIDTH-1:0] wr_data,
  input  logic [1:0]           rd_addr,
  output logic [BUS_WIDTH-1:0] rd_data,
  // ALU-facing side
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  output logic [3:0]           alu_opcode,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic                 alu_carry_out,
  input  logic                 alu_borrow,
  input  logic                 alu_zero,
  input  logic                 alu_parity,
  input  logic                 alu_invalid_op,
  // completion channel
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [BUS_WIDTH-1:0] done_result,
  output logic                 done_err,
  output logic [3:0]           status,
  output logic [15:0]          op_count,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // status bit positions: {zero, parity, carry, borrow}
  localparam int c_ST_ZERO   = 3;
  localparam int c_ST_PARITY = 2;
  localparam int c_ST_CARRY  = 1;
  localparam int c_ST_BORROW = 0;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_run;
  logic [BUS_WIDTH-1:0] r_regs [4];
  logic [3:0]           r_status;
  logic [3:0]           r_opcode;
  logic [1:0]           r_rd;
  logic [1:0]           r_rs1;
  logic [1:0]           r_rs2;
  logic [BUS_WIDTH-1:0] r_y;
  logic                 r_zero;
  logic                 r_parity;
  logic                 r_carry;
  logic                 r_borrow;
  logic                 r_invalid;
  logic [15:0]          r_op_count;
  logic [7:0]           r_err_count;
  logic                 w_accept;
  logic                 w_retire;

  // State register; reset parks the machine in IDLE and drops any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Goes high on the first edge after reset release so instr_ready stays low until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Next-state decode and all handshake / ALU-facing outputs.
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    done_valid   = 1'b0;
    w_accept     = 1'b0;
    w_retire     = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_opcode   = 4'd0;
    alu_carry_in = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = r_run;
        if (instr_valid && r_run) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a        = r_regs[r_rs1];
        alu_b        = r_regs[r_rs2];
        alu_opcode   = r_opcode;
        alu_carry_in = r_status[c_ST_CARRY];
        w_next_state = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          w_retire     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latch the instruction fields at accept so the instr bus is free afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 4'd0;
      r_rd     <= 2'd0;
      r_rs1    <= 2'd0;
      r_rs2    <= 2'd0;
    end else if (w_accept) begin
      r_opcode <= instr[9:6];
      r_rd     <= instr[5:4];
      r_rs1    <= instr[3:2];
      r_rs2    <= instr[1:0];
    end
  end

  // Capture the ALU response at the end of the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_zero    <= 1'b0;
      r_parity  <= 1'b0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_invalid <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_y       <= alu_y;
      r_zero    <= alu_zero;
      r_parity  <= alu_parity;
      r_carry   <= alu_carry_out;
      r_borrow  <= alu_borrow;
      r_invalid <= alu_invalid_op;
    end
  end

  // Register file: external loads only in IDLE, writeback only on a valid retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else if ((r_state == S_IDLE) && wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end else if (w_retire && !r_invalid) begin
      r_regs[r_rd] <= r_y;
    end
  end

  // Status flags and saturating counters update together at retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status    <= 4'd0;
      r_op_count  <= 16'd0;
      r_err_count <= 8'd0;
    end else if (w_retire) begin
      if (r_invalid) begin
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else begin
        r_status[c_ST_ZERO]   <= r_zero;
        r_status[c_ST_PARITY] <= r_parity;
        r_status[c_ST_CARRY]  <= r_carry;
        r_status[c_ST_BORROW] <= r_borrow;
        if (r_op_count != 16'hFFFF) begin
          r_op_count <= r_op_count + 16'd1;
        end
      end
    end
  end

  assign rd_data     = r_regs[rd_addr];
  assign done_result = r_y;
  assign done_err    = r_invalid;
  assign status      = r_status;
  assign op_count    = r_op_count;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire
